seq_cla_adder: RTL and testbench

SEQ_CLA_ADDER -- requirements
Module: seq_cla_adder

---
 rtl/seq_cla_adder_pkg.sv | 15 +
 rtl/seq_cla_adder_slice4.sv | 29 ++
 rtl/seq_cla_adder.sv | 110 +++++++++++
 tb/tb_seq_cla_adder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_cla_adder_pkg.sv
// Shared constants for the sequential slice-at-a-time carry-lookahead adder.
package seq_cla_adder_pkg;

    localparam int SLICE_W = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Width of a counter spanning n slices; at least one bit so NSLICE=1 still has a register.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_cla_adder_slice4.sv
// Combinational 4-bit carry-lookahead slice with group propagate/generate outputs.
module cla_slice4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       P,
    output logic       G
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        G    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        P    = &p;
        cout = G | (P & cin);
        sum  = p ^ c;
    end

endmodule

// File: rtl/seq_cla_adder.sv
// Sequential adder: one shared 4-bit lookahead slice is stepped across the word,
// LSB slice first, with ready/valid handshakes on both sides.
module seq_cla_adder
    import seq_cla_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             P,
    output logic             G
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int KW     = idx_w(NSLICE);
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    logic [1:0]         state;
    logic [KW-1:0]      k;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               carry;

    logic [SLICE_W-1:0] sa;
    logic [SLICE_W-1:0] sb;
    logic [SLICE_W-1:0] ss;
    logic               sc;
    logic               sp;
    logic               sg;
    logic               c_msb;

    always_comb begin
        sa    = a_r[SLICE_W*int'(k) +: SLICE_W];
        sb    = b_r[SLICE_W*int'(k) +: SLICE_W];
        // Carry into the slice MSB recovered from its sum bit, so the chain is not duplicated.
        c_msb = ss[SLICE_W-1] ^ sa[SLICE_W-1] ^ sb[SLICE_W-1];
    end

    cla_slice4 u_slice (
        .a    (sa),
        .b    (sb),
        .cin  (carry),
        .sum  (ss),
        .cout (sc),
        .P    (sp),
        .G    (sg)
    );

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            P     <= 1'b0;
            G     <= 1'b0;
            carry <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        carry <= cin;
                        k     <= '0;
                        P     <= 1'b1;
                        G     <= 1'b0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    sum[SLICE_W*int'(k) +: SLICE_W] <= ss;
                    carry <= sc;
                    P     <= P & sp;
                    G     <= sg | (sp & G);
                    if (k == K_LAST) begin
                        cout  <= sc;
                        ovf   <= c_msb ^ sc;
                        state <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_cla_adder.sv
// Bench for seq_cla_adder (WIDTH=16): directed vector table, handshake corner cases,
// and a random back-to-back stream checked through an expected-result queue.
module tb_seq_cla_adder;

    localparam int W  = 16;
    localparam int NS = W / 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         P;
        logic         G;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        res_t         exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         P;
    logic         G;

    seq_cla_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .P         (P),
        .G         (G)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_acc = 0;
    bit   have_acc = 1'b0;
    bit   b2b      = 1'b0;
    bit   prev_ov  = 1'b0;
    res_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference uses plain wide arithmetic, independent of any lookahead structure.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        res_t         r;
        logic [W:0]   s;
        logic [W:0]   g;
        s      = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        g      = {1'b0, x} + {1'b0, y};
        r.sum  = s[W-1:0];
        r.cout = s[W];
        r.ovf  = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
        r.P    = &(x ^ y);
        r.G    = g[W];
        return r;
    endfunction

    function automatic res_t dut_res();
        res_t r;
        r.sum = sum; r.cout = cout; r.ovf = ovf; r.P = P; r.G = G;
        return r;
    endfunction

    // Monitor: push on accept, pop on result handoff, time latency and accept spacing.
    always @(negedge clk) begin
        if (rst) begin
            prev_ov <= 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                sb.push_back(model(a, b, cin));
                if (b2b && have_acc) check("spacing", 32'(cyc + 1 - last_acc), 32'(NS + 2));
                last_acc = cyc + 1;
                have_acc = 1'b1;
            end
            if (out_valid && !prev_ov) check("latency", 32'(cyc - last_acc), 32'(NS));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 32'(out_valid), 32'(0));
                end else begin
                    res_t e;
                    e = sb.pop_front();
                    check("result", 32'(dut_res()), 32'(e));
                end
            end
            prev_ov <= out_valid;
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        int t;
        @(posedge clk); #1;
        a = x; b = y; cin = ci; in_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 50);
        check("accept", 32'(in_ready), 32'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!out_valid && t < 50);
        check("out_valid_timeout", 32'(out_valid), 32'(1));
    endtask

    task automatic release_result();
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
    endtask

    vec_t vecs[7];

    initial begin
        res_t e;
        int   t;
        int   ov_seen;

        vecs[0] = '{16'h0000, 16'h0000, 1'b0, '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b1}};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[4] = '{16'h0001, 16'h0001, 1'b1, '{16'h0003, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[5] = '{16'h1234, 16'h4321, 1'b0, '{16'h5555, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, '{16'h0000, 1'b1, 1'b1, 1'b0, 1'b1}};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_outputs", 32'(dut_res()), 32'(0));

        for (int i = 0; i < 7; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].cin);
            wait_valid();
            check($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].exp.sum));
            check($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].exp.cout));
            check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].exp.ovf));
            check($sformatf("vec%0d_P", i), 32'(P), 32'(vecs[i].exp.P));
            check($sformatf("vec%0d_G", i), 32'(G), 32'(vecs[i].exp.G));
            release_result();
        end

        // Hold in DONE with a competing in_valid, then release with in_valid still high.
        e = model(16'h1234, 16'h4321, 1'b1);
        send(16'h1234, 16'h4321, 1'b1);
        wait_valid();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            a = 16'hAAAA; b = 16'h5555; cin = 1'b1; in_valid = 1'b1;
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 32'(1));
            check("hold_in_ready", 32'(in_ready), 32'(0));
            check("hold_result", 32'(dut_res()), 32'(e));
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'(1));
        check("release_out_valid", 32'(out_valid), 32'(0));

        // Reset on the second BUSY edge aborts the operation.
        send(16'hDEAD, 16'hBEEF, 1'b1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("abort_in_ready", 32'(in_ready), 32'(1));
        check("abort_out_valid", 32'(out_valid), 32'(0));
        check("abort_outputs", 32'(dut_res()), 32'(0));
        ov_seen = 0;
        for (int i = 0; i < NS + 3; i++) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
        check("abort_no_valid", 32'(ov_seen), 32'(0));
        e = model(16'h00F0, 16'h0F10, 1'b1);
        send(16'h00F0, 16'h0F10, 1'b1);
        wait_valid();
        check("post_abort_result", 32'(dut_res()), 32'(e));
        release_result();

        // Back-to-back random stream with in_valid held high throughout.
        @(posedge clk); #1;
        have_acc = 1'b0;
        b2b = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            in_valid = 1'b1;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!in_ready && t < 50);
            check("b2b_accept", 32'(in_ready), 32'(1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("drain", 32'(sb.size()), 32'(0));
        b2b = 1'b0;
        out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
